// File: rtl/ram_pkg.sv
// Shared types for the clocked word RAM: FSM states, request decode, read latency bounds.
package ram_pkg;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE, OP_BAD} op_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic op_e decode_op(input logic rd, input logic wr);
    case ({rd, wr})
      2'b10:   return OP_READ;
      2'b01:   return OP_WRITE;
      2'b11:   return OP_BAD;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return delay line, LAT stages of {valid, data, err}; never stalls.
// Only valid/err are reset so a flush drops in-flight results without touching data flops.
module ram_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              err_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] dat_o,
  output logic              err_o
);

  logic [LAT-1:0]        vld_q;
  logic [LAT-1:0]        err_q;
  logic [LAT*DATA_W-1:0] dat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
    end else begin
      vld_q <= LAT'({vld_q, vld_i});
      err_q <= LAT'({err_q, err_i});
    end
  end

  always_ff @(posedge clk) begin
    dat_q <= (LAT*DATA_W)'({dat_q, dat_i});
  end

  assign vld_o = vld_q[LAT-1];
  assign err_o = err_q[LAT-1];
  assign dat_o = dat_q[LAT*DATA_W-1 -: DATA_W];

endmodule

// File: rtl/ram_ctrl.sv
// Single-port word RAM with byte enables, hardware zeroing engine and READ_LAT-cycle read return.
// ready is low while clearing; requests seen with ready low are dropped and must be held by the master.
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  OPERATION_FLAG,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic                  clear_req,
  output logic                  ready,
  output logic [DATA_W-1:0]     data_o,
  output logic                  rd_valid,
  output logic                  err
);

  localparam int BYTES = DATA_W / 8;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT   = (READ_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (READ_LAT > RD_LAT_MAX) ? RD_LAT_MAX : READ_LAT;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               clr_pend_q, clr_pend_d;
  logic               werr_q, werr_d;
  logic               rd_vld_q, rd_err_q;
  logic [DATA_W-1:0]  rd_dat_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  op_e                op;
  logic               in_range;
  logic [PTR_W-1:0]   idx;
  logic               rd_en, wr_en;
  logic               pipe_vld, pipe_err;
  logic [DATA_W-1:0]  pipe_dat;

  assign ready    = (state_q == ST_IDLE);
  assign in_range = ({1'b0, address} < DEPTH_A);
  assign idx      = address[PTR_W-1:0];

  always_comb begin
    op = OP_NONE;
    if (OPERATION_FLAG && ready) op = decode_op(READ, WRITE);
  end

  assign rd_en  = (op == OP_READ);
  assign wr_en  = (op == OP_WRITE) && in_range;
  assign werr_d = (op == OP_BAD) || ((op == OP_WRITE) && !in_range);

  // clear_req is registered first, so CLEAR starts one edge after it is sampled
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_pend_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_IDLE: begin
        clr_pend_d = clear_req && !clr_pend_q;
        if (clr_pend_q) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      clr_pend_q <= 1'b0;
      werr_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_pend_q <= clr_pend_d;
      werr_q     <= werr_d;
      rd_vld_q   <= rd_en;
      rd_err_q   <= rd_en && !in_range;
    end
  end

  // Out-of-range reads return zero rather than whatever aliases at idx
  always_ff @(posedge clk) begin
    if (rd_en) rd_dat_q <= in_range ? mem_q[idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < BYTES; k++) begin
        if (be[k]) mem_q[idx][8*k +: 8] <= data_i[8*k +: 8];
      end
    end
  end

  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .LAT    (LAT)
  ) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .vld_i (rd_vld_q),
    .dat_i (rd_dat_q),
    .err_i (rd_err_q),
    .vld_o (pipe_vld),
    .dat_o (pipe_dat),
    .err_o (pipe_err)
  );

  assign rd_valid = pipe_vld;
  assign data_o   = pipe_vld ? pipe_dat : '0;
  assign err      = werr_q | pipe_err;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: DEPTH=16, READ_LAT=2, 16-bit words.
module tb_ram_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 16;
  localparam int RLAT   = 2;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_i;
  logic [1:0]        be;
  logic              OPERATION_FLAG, READ, WRITE, clear_req;
  logic              ready, rd_valid, err;
  logic [DATA_W-1:0] data_o;

  ram_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .READ_LAT (RLAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .address        (address),
    .data_i         (data_i),
    .be             (be),
    .OPERATION_FLAG (OPERATION_FLAG),
    .READ           (READ),
    .WRITE          (WRITE),
    .clear_req      (clear_req),
    .ready          (ready),
    .data_o         (data_o),
    .rd_valid       (rd_valid),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flag;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] dat;
    logic [1:0]  be;
    logic        exp_rdv;
    logic [15:0] exp_dat;
    logic        exp_err;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle();
    OPERATION_FLAG = 1'b0;
    READ      = 1'b0;
    WRITE     = 1'b0;
    address   = '0;
    data_i    = '0;
    be        = '0;
    clear_req = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    OPERATION_FLAG = v.flag;
    READ    = v.rd;
    WRITE   = v.wr;
    address = v.addr;
    data_i  = v.dat;
    be      = v.be;
  endtask

  // Signature slots {rd_valid, err, data_o} after edges N, N+1, N+2 (N = request edge)
  task automatic do_op(input vec_t v, output logic [53:0] sig);
    @(negedge clk);
    drive(v);
    @(posedge clk); #1;
    sig[53:36] = {rd_valid, err, data_o};
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    sig[35:18] = {rd_valid, err, data_o};
    @(posedge clk); #1;
    sig[17:0]  = {rd_valid, err, data_o};
  endtask

  function automatic logic [53:0] exp_sig(input vec_t v);
    if (v.exp_rdv) return {18'h0, 18'h0, 1'b1, v.exp_err, v.exp_dat};
    return {1'b0, v.exp_err, 16'h0, 36'h0};
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready && n < 200);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [53:0] sig;
  vec_t        v;
  int          n;
  logic        seen;
  logic [7:0]  bs_addr [3];
  logic [15:0] bs_dat  [3];

  initial begin
    //           flag  rd    wr    addr    dat        be     rdv   exp_dat    err
    vt[0]  = '{1'b1, 1'b1, 1'b0, 8'd10,  16'h0000, 2'b00, 1'b1, 16'h0000, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 8'd3,   16'hABCD, 2'b11, 1'b0, 16'h0000, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 8'd3,   16'h1200, 2'b10, 1'b0, 16'h0000, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 8'd3,   16'h0000, 2'b00, 1'b1, 16'h12CD, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 8'd4,   16'h5555, 2'b01, 1'b0, 16'h0000, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 8'd4,   16'h0000, 2'b00, 1'b1, 16'h0055, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 8'd4,   16'hFFFF, 2'b00, 1'b0, 16'h0000, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 8'd4,   16'h0000, 2'b00, 1'b1, 16'h0055, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 8'd3,   16'hFFFF, 2'b11, 1'b0, 16'h0000, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 8'd3,   16'h0000, 2'b00, 1'b1, 16'h12CD, 1'b0};
    vt[10] = '{1'b1, 1'b1, 1'b0, 8'd16,  16'h0000, 2'b00, 1'b1, 16'h0000, 1'b1};
    vt[11] = '{1'b1, 1'b0, 1'b1, 8'd16,  16'h7777, 2'b11, 1'b0, 16'h0000, 1'b1};
    vt[12] = '{1'b1, 1'b1, 1'b0, 8'd0,   16'h0000, 2'b00, 1'b1, 16'h0000, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 8'd0,   16'h4444, 2'b11, 1'b0, 16'h0000, 1'b0};
    vt[14] = '{1'b0, 1'b0, 1'b1, 8'd0,   16'h4444, 2'b11, 1'b0, 16'h0000, 1'b0};
    vt[15] = '{1'b1, 1'b1, 1'b0, 8'd0,   16'h0000, 2'b00, 1'b1, 16'h0000, 1'b0};
    vt[16] = '{1'b1, 1'b1, 1'b0, 8'd200, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b1};

    bs_addr = '{8'd3, 8'd4, 8'd10};
    bs_dat  = '{16'h12CD, 16'h0055, 16'h7A69};

    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ready, rd_valid, err, data_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    check("ready_after_reset", 64'(n), 64'd16);

    for (int i = 0; i < NV; i++) begin
      do_op(vt[i], sig);
      check($sformatf("vec%0d", i), 64'(sig), 64'(exp_sig(vt[i])));
    end

    // Write then read on the very next edge: read sees new data RLAT edges later
    @(negedge clk);
    OPERATION_FLAG = 1'b1; WRITE = 1'b1; address = 8'd10; data_i = 16'd31337; be = 2'b11;
    @(posedge clk); #1;
    check("raw_wr_resp", {rd_valid, err}, 2'b00);
    @(negedge clk);
    WRITE = 1'b0; READ = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    check("raw_early", {rd_valid, err, data_o}, 18'h0);
    @(posedge clk); #1;
    check("raw_read", {rd_valid, err, data_o}, {1'b1, 1'b0, 16'd31337});

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 3) begin
        OPERATION_FLAG = 1'b1; READ = 1'b1; address = bs_addr[i];
      end else begin
        idle();
      end
      @(posedge clk); #1;
      if (i >= 2) check($sformatf("stream%0d", i - 2), {rd_valid, err, data_o}, {1'b1, 1'b0, bs_dat[i-2]});
    end

    for (int i = 0; i < DEPTH; i++) begin
      v = '{1'b1, 1'b0, 1'b1, 8'(i), 16'hA000 + 16'(i), 2'b11, 1'b0, 16'h0, 1'b0};
      do_op(v, sig);
      check($sformatf("fill%0d", i), 64'(sig), 64'(exp_sig(v)));
    end

    // clear_req together with a read of word 5; the read must return pre-clear data
    @(negedge clk);
    OPERATION_FLAG = 1'b1; READ = 1'b1; address = 8'd5; clear_req = 1'b1;
    @(posedge clk); #1;
    check("clr_ready_pending", 64'(ready), 64'd1);
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    check("clr_ready_drop", {ready, rd_valid}, 2'b00);
    @(posedge clk); #1;
    check("clr_inflight", {rd_valid, err, data_o}, {1'b1, 1'b0, 16'hA005});
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    wait_ready(n);
    // CLEAR entered at edge N+1; ready must return at N+17, i.e. 14 edges after N+3
    check("clr_ready_low", 64'(n), 64'd14);

    for (int i = 0; i < DEPTH; i++) begin
      v = '{1'b1, 1'b1, 1'b0, 8'(i), 16'h0, 2'b00, 1'b1, 16'h0000, 1'b0};
      do_op(v, sig);
      check($sformatf("post_clr%0d", i), 64'(sig), 64'(exp_sig(v)));
    end

    v = '{1'b1, 1'b0, 1'b1, 8'd2, 16'hBEEF, 2'b11, 1'b0, 16'h0, 1'b0};
    do_op(v, sig);

    // Two reads in flight when rst hits: neither may surface
    @(negedge clk);
    OPERATION_FLAG = 1'b1; READ = 1'b1; address = 8'd1;
    @(posedge clk);
    @(negedge clk);
    address = 8'd2;
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    #1;
    check("rst_async", {ready, rd_valid, err, data_o}, 19'h0);
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen = seen | rd_valid | err;
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      seen = seen | rd_valid | err;
      if (n == 2) begin
        OPERATION_FLAG = 1'b1; WRITE = 1'b1; address = 8'd0; data_i = 16'h9999; be = 2'b11;
      end else if (n == 5) begin
        idle();
      end
    end while (!ready && n < 200);
    idle();
    check("rst_no_stale", 64'(seen), 64'd0);
    check("rst_ready_lat", 64'(n), 64'd16);

    v = '{1'b1, 1'b1, 1'b0, 8'd2, 16'h0, 2'b00, 1'b1, 16'h0000, 1'b0};
    do_op(v, sig);
    check("rst_zeroed", 64'(sig), 64'(exp_sig(v)));
    v = '{1'b1, 1'b1, 1'b0, 8'd0, 16'h0, 2'b00, 1'b1, 16'h0000, 1'b0};
    do_op(v, sig);
    check("busy_write_dropped", 64'(sig), 64'(exp_sig(v)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
